// File: rtl/counter_12_sched.sv
// Round-robin scheduler that lends a shared modulo-MOD tick counter to one of NREQ
// requesters at a time, driving valid_count for exactly the granted burst length.
module counter_12_sched #(
    parameter int NREQ = 4,
    parameter int MOD  = 12,
    parameter int CW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   len,
    input  logic                 hold,
    output logic                 valid_count,
    output logic [CW-1:0]        cnt,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [NREQ-1:0]      done,
    output logic [CW-1:0]        remain
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, owner, sel;
    logic            found;
    logic [CW-1:0]   sel_len;

    // First requester at or above ptr, wrapping; sel is only used when found.
    always_comb begin
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                sel   = PW'(idx);
                found = 1'b1;
            end
        end
    end

    assign sel_len = len[int'(sel)*CW +: CW];

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (found) state_nx = (sel_len != '0) ? S_RUN : S_DONE;
            S_RUN:  if (!hold && remain == CW'(1)) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign valid_count = (state == S_RUN) && !hold;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ptr    <= '0;
            owner  <= '0;
            grant  <= '0;
            remain <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (found) begin
                    grant  <= NREQ'(1) << sel;
                    owner  <= sel;
                    remain <= sel_len;
                end
                S_RUN: if (!hold) begin
                    remain <= remain - 1'b1;
                    cnt    <= (cnt == CW'(MOD-1)) ? '0 : cnt + 1'b1;
                end
                S_DONE: begin
                    grant <= '0;
                    ptr   <= (int'(owner) == NREQ-1) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
